// File: rtl/time_of_day_counter.sv
// BCD hours:minutes:seconds time-of-day counter advanced by rising edges of a 1 Hz tick,
// with validated synchronous time-set, optional 12-hour display and second/day pulses.
module time_of_day_counter #(
  parameter bit         MODE_12H   = 1'b0,
  parameter logic [7:0] RESET_HOUR = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       ENA,
  input  logic       iTICK,
  input  logic       iSET,
  input  logic [7:0] iSET_H,
  input  logic [7:0] iSET_M,
  input  logic [7:0] iSET_S,
  output logic [7:0] oSEC,
  output logic [7:0] oMIN,
  output logic [7:0] oHOUR,
  output logic       oPM,
  output logic       oSEC_PULSE,
  output logic       oDAY_PULSE,
  output logic       oSET_ERR
);

  logic [7:0] sec_q, min_q, hour_q;
  logic       tick_d;
  logic       sec_pulse_q, day_pulse_q, set_err_q;

  logic       rise;
  logic       set_valid;
  logic       sec_wrap, min_wrap, day_wrap;
  logic [7:0] sec_nx, min_nx, hour_nx;
  logic [3:0] hour_mod16, pm_hour;
  logic [7:0] hour_12;

  function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] == 4'd5) return 8'h00;
    return {v[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] bcd_inc_24(input logic [7:0] v);
    if (v == 8'h23)     return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  always_comb begin
    rise      = iTICK & ~tick_d;
    set_valid = bcd_ok(iSET_H, 8'h23) && bcd_ok(iSET_M, 8'h59) && bcd_ok(iSET_S, 8'h59);
    sec_wrap  = (sec_q == 8'h59);
    min_wrap  = (min_q == 8'h59);
    day_wrap  = sec_wrap && min_wrap && (hour_q == 8'h23);
    sec_nx    = bcd_inc_60(sec_q);
    min_nx    = sec_wrap ? bcd_inc_60(min_q) : min_q;
    hour_nx   = (sec_wrap && min_wrap) ? bcd_inc_24(hour_q) : hour_q;
  end

  // Set has priority over the tick; a tick coinciding with a set is dropped.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= RESET_HOUR;
      tick_d      <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      tick_d      <= iTICK;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
      if (iSET) begin
        if (set_valid) begin
          sec_q  <= iSET_S;
          min_q  <= iSET_M;
          hour_q <= iSET_H;
        end else begin
          set_err_q <= 1'b1;
        end
      end else if (rise && ENA) begin
        sec_q       <= sec_nx;
        min_q       <= min_nx;
        hour_q      <= hour_nx;
        sec_pulse_q <= 1'b1;
        day_pulse_q <= day_wrap;
      end
    end
  end

  // Binary hour modulo 16 is enough here: hour - 12 always lands in 1..11 for hours 13..23.
  always_comb begin
    hour_mod16 = hour_q[7:4] * 4'd10 + hour_q[3:0];
    pm_hour    = hour_mod16 - 4'd12;
    if (hour_q == 8'h00)       hour_12 = 8'h12;
    else if (hour_q <= 8'h12)  hour_12 = hour_q;
    else if (pm_hour >= 4'd10) hour_12 = {4'h1, pm_hour - 4'd10};
    else                       hour_12 = {4'h0, pm_hour};
  end

  assign oSEC       = sec_q;
  assign oMIN       = min_q;
  assign oHOUR      = MODE_12H ? hour_12 : hour_q;
  assign oPM        = MODE_12H && (hour_q >= 8'h12);
  assign oSEC_PULSE = sec_pulse_q;
  assign oDAY_PULSE = day_pulse_q;
  assign oSET_ERR   = set_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: a 24h and a 12h instance share stimulus and are checked
// every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;

  logic       CLOCK_50, RST, ENA, iTICK, iSET;
  logic [7:0] iSET_H, iSET_M, iSET_S;
  logic [7:0] sec_a, min_a, hour_a, sec_b, min_b, hour_b;
  logic       pm_a, sp_a, dp_a, err_a, pm_b, sp_b, dp_b, err_b;

  int checks = 0;
  int errors = 0;
  int t[2];
  bit exp_sp[2], exp_dp[2], exp_err[2];
  bit prev_tick;
  int pulse_seen;

  localparam int RESET_H_A = 0;
  localparam int RESET_H_B = 13;

  time_of_day_counter #(.MODE_12H(1'b0), .RESET_HOUR(8'h00)) dut_a (
    .CLOCK_50(CLOCK_50), .RST(RST), .ENA(ENA), .iTICK(iTICK), .iSET(iSET),
    .iSET_H(iSET_H), .iSET_M(iSET_M), .iSET_S(iSET_S),
    .oSEC(sec_a), .oMIN(min_a), .oHOUR(hour_a), .oPM(pm_a),
    .oSEC_PULSE(sp_a), .oDAY_PULSE(dp_a), .oSET_ERR(err_a)
  );

  time_of_day_counter #(.MODE_12H(1'b1), .RESET_HOUR(8'h13)) dut_b (
    .CLOCK_50(CLOCK_50), .RST(RST), .ENA(ENA), .iTICK(iTICK), .iSET(iSET),
    .iSET_H(iSET_H), .iSET_M(iSET_M), .iSET_S(iSET_S),
    .oSEC(sec_b), .oMIN(min_b), .oHOUR(hour_b), .oPM(pm_b),
    .oSEC_PULSE(sp_b), .oDAY_PULSE(dp_b), .oSET_ERR(err_b)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int max_v);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (int'(b[7:4]) * 10 + int'(b[3:0]) <= max_v);
  endfunction

  function automatic int field_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    t[0] = RESET_H_A * 3600;
    t[1] = RESET_H_B * 3600;
    prev_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_sp[i] = 1'b0; exp_dp[i] = 1'b0; exp_err[i] = 1'b0;
    end
  endtask

  // Reference behaviour for one clock edge given the inputs present at that edge.
  task automatic model_step();
    bit ok;
    ok = field_ok(iSET_H, 23) && field_ok(iSET_M, 59) && field_ok(iSET_S, 59);
    for (int i = 0; i < 2; i++) begin
      exp_sp[i] = 1'b0; exp_dp[i] = 1'b0; exp_err[i] = 1'b0;
      if (iSET) begin
        if (ok) t[i] = field_val(iSET_H) * 3600 + field_val(iSET_M) * 60 + field_val(iSET_S);
        else    exp_err[i] = 1'b1;
      end else if (ENA && iTICK && !prev_tick) begin
        t[i] = (t[i] + 1) % 86400;
        exp_sp[i] = 1'b1;
        exp_dp[i] = (t[i] == 0);
      end
    end
    prev_tick = iTICK;
  endtask

  task automatic check_dut(input string n, input int idx, input bit mode12,
                           input logic [7:0] sec, input logic [7:0] min, input logic [7:0] hour,
                           input logic pm, input logic sp, input logic dp, input logic err);
    int h, disp;
    h    = t[idx] / 3600;
    disp = mode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    chk({n, ".sec"},  sec,  to_bcd(t[idx] % 60));
    chk({n, ".min"},  min,  to_bcd((t[idx] / 60) % 60));
    chk({n, ".hour"}, hour, to_bcd(disp));
    chk({n, ".pm"},   {7'd0, pm},  {7'd0, mode12 && (h >= 12)});
    chk({n, ".secp"}, {7'd0, sp},  {7'd0, exp_sp[idx]});
    chk({n, ".dayp"}, {7'd0, dp},  {7'd0, exp_dp[idx]});
    chk({n, ".err"},  {7'd0, err}, {7'd0, exp_err[idx]});
  endtask

  task automatic check_output();
    check_dut("d24", 0, 1'b0, sec_a, min_a, hour_a, pm_a, sp_a, dp_a, err_a);
    check_dut("d12", 1, 1'b1, sec_b, min_b, hour_b, pm_b, sp_b, dp_b, err_b);
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    #1;
    model_step();
    if (sp_a) pulse_seen++;
    check_output();
  endtask

  task automatic tick();
    iTICK = 1'b1; cycle();
    iTICK = 1'b0; cycle();
  endtask

  task automatic apply_stimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    iSET = 1'b1; iSET_H = h; iSET_M = m; iSET_S = s;
    cycle();
    iSET = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ENA = 1'b0; iTICK = 1'b0; iSET = 1'b0;
    iSET_H = 8'h00; iSET_M = 8'h00; iSET_S = 8'h00;
    pulse_seen = 0;
    #3;
    model_reset();
    check_output();
    #3 RST = 1'b0;

    $display("[TB] five ticks from reset");
    ENA = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("five.sec", sec_a, 8'h05);
    chk("five.pulses", 8'(pulse_seen), 8'd5);

    $display("[TB] day wrap");
    apply_stimulus(8'h23, 8'h59, 8'h58);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap.sec", sec_a, 8'h01);

    $display("[TB] hour digit carry and rejected sets");
    apply_stimulus(8'h09, 8'h59, 8'h59);
    tick();
    chk("carry.hour", hour_a, 8'h10);
    apply_stimulus(8'h11, 8'h60, 8'h00);
    apply_stimulus(8'h11, 8'h00, 8'h3A);
    apply_stimulus(8'h24, 8'h00, 8'h00);
    apply_stimulus(8'h1A, 8'h00, 8'h00);
    chk("reject.hour", hour_a, 8'h10);

    $display("[TB] enable gating");
    ENA = 1'b0;
    pulse_seen = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("frozen.pulses", 8'(pulse_seen), 8'd0);
    iTICK = 1'b1; cycle();
    ENA = 1'b1; cycle(); cycle();
    chk("level.sec", sec_a, 8'h00);
    iTICK = 1'b0; cycle();
    tick();
    chk("next_edge.sec", sec_a, 8'h01);

    $display("[TB] set coincident with tick, async reset");
    iSET = 1'b1; iSET_H = 8'h12; iSET_M = 8'h34; iSET_S = 8'h56; iTICK = 1'b1;
    cycle();
    iSET = 1'b0; iTICK = 1'b0; cycle();
    chk("set_vs_tick.sec", sec_a, 8'h56);
    apply_stimulus(8'h07, 8'h15, 8'h29);
    tick();
    iTICK = 1'b1;
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_output();
    chk("async.hour24", hour_a, 8'h00);
    chk("async.hour12", hour_b, 8'h01);
    iTICK = 1'b0;
    #2 RST = 1'b0;
    cycle();

    $display("[TB] 12h display");
    apply_stimulus(8'h00, 8'h00, 8'h00);
    chk("h12.midnight", hour_b, 8'h12);
    apply_stimulus(8'h12, 8'h00, 8'h00);
    apply_stimulus(8'h20, 8'h00, 8'h00);
    chk("h12.twenty", hour_b, 8'h08);
    apply_stimulus(8'h21, 8'h00, 8'h00);
    chk("h12.twentyone", hour_b, 8'h09);
    apply_stimulus(8'h23, 8'h00, 8'h00);
    apply_stimulus(8'h11, 8'h59, 8'h59);
    tick();
    chk("h12.noon_pm", {7'd0, pm_b}, 8'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      ENA   = ($urandom_range(0, 7) != 0);
      iTICK = ($urandom_range(0, 2) == 0) ? ~iTICK : iTICK;
      iSET  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        iSET_H = to_bcd($urandom_range(0, 23));
        iSET_M = to_bcd($urandom_range(0, 59));
        iSET_S = to_bcd($urandom_range(50, 59));
      end else begin
        iSET_H = 8'($urandom);
        iSET_M = 8'($urandom);
        iSET_S = 8'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Downstream consumer of the clock divider's square-wave output (`iTICK`, 1 Hz after division).
- Detects each rising edge of `iTICK` synchronously in the `CLOCK_50` domain and advances a BCD hours:minutes:seconds time-of-day.
- Drives the seven-segment decode stage.
- Supports synchronous time-set with range validation, optional 12-hour display, and second/day pulse outputs.

Parameters:
- `MODE_12H`, 0: 0 = `oHOUR` shows 00-23; 1 = `oHOUR` shows 12,01-11 and `oPM` is valid.
- `RESET_HOUR`, 8'h00: BCD hour loaded at reset, 24h encoding.

Ports:
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  asynchronous active-high reset.
- `ENA`  in  1  count enable; 0 freezes time.
- `iTICK`  in  1  divided clock from upstream; each rising edge = one second.
- `iSET`  in  1  single-cycle request to load `iSET_H`/`iSET_M`/`iSET_S`.
- `iSET_H`  in  8  BCD hour, 24h encoding, 00-23.
- `iSET_M`  in  8  BCD minute, 00-59.
- `iSET_S`  in  8  BCD second, 00-59.
- `oSEC`  out  8  BCD seconds.
- `oMIN`  out  8  BCD minutes.
- `oHOUR`  out  8  BCD hours, per `MODE_12H`.
- `oPM`  out  1  1 when internal hour ≥ 12; forced 0 when `MODE_12H` = 0.
- `oSEC_PULSE`  out  1  one-cycle pulse on each accepted increment.
- `oDAY_PULSE`  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- `oSET_ERR`  out  1  one-cycle pulse when a set request is rejected.

Behaviour:

Reset (`RST` = 1, asynchronous):
- sec = 00, min = 00, hour = `RESET_HOUR`.
- `tick_d` = 0.
- All pulses = 0.
- Takes effect immediately, including mid-set or mid-increment.
- Reset deassertion is synchronous to `CLOCK_50` at the system level; no special handling is required here.

Edge detect:
- `tick_d` registers `iTICK` every cycle, regardless of `ENA`.
- `rise` = `iTICK` & ~`tick_d`.
- Because `tick_d` always tracks, a level already high when `ENA` rises produces no increment.

Increment:
- Occurs on the `CLOCK_50` edge where `rise` = 1, `ENA` = 1 and `iSET` = 0. Registered outputs change after that same edge: zero added cycles of latency.
- BCD digit rules:
  - Each low nibble wraps 9 → 0 and carries.
  - sec high nibble wraps 5 → 0 with carry to min; min likewise carries to hour.
  - Hour wraps 23 → 00.
- `oSEC_PULSE` = 1 for exactly the cycle after the increment edge.
- `oDAY_PULSE` = 1 in that same cycle only on the 23:59:59 → 00:00:00 wrap.

Set:
- On an edge with `iSET` = 1, all six BCD nibbles are validated:
  - each nibble ≤ 9;
  - hour ≤ 23;
  - min ≤ 59;
  - sec ≤ 59.
- Valid: all three fields load on that edge; no `oSEC_PULSE`.
- Invalid: time is unchanged and `oSET_ERR` pulses one cycle.
- Set is accepted regardless of `ENA`.
- Set coincident with `rise`: set wins and that second is dropped, with no pulse.
- `iSET` held high for multiple cycles reloads every cycle; the tick stays suppressed.

12h display (combinational from the internal 24h hour):
- 00 → 12, AM.
- 01-11 → unchanged, AM.
- 12 → 12, PM.
- 13-23 → hour − 12 in BCD, PM.
- Converts 20-23 with BCD borrow correctly: e.g. 20 → 08, 21 → 09.

Internal state is always 24h BCD. There are no illegal reachable states; any illegal value is reachable only via set, and set rejects it.

Test Plan:
- Reset with `RESET_HOUR` = 8'h00, `ENA` = 1, five `iTICK` rising edges → `oSEC` = 05, five `oSEC_PULSE` pulses, `oMIN` = 00.
- Set 23:59:58 then three ticks → 23:59:59, then 00:00:00 with `oDAY_PULSE` high for exactly 1 cycle, then 00:00:01.
- Set 09:59:59, one tick → 10:00:00, confirming BCD carry across hour digits; set with `iSET_M` = 8'h60 → `oSET_ERR` pulse and time unchanged; set with `iSET_S` = 8'h3A → rejected.
- `ENA` = 0 across 4 ticks → time frozen, no pulses; raise `ENA` while `iTICK` is high → no increment until the next rising edge.
- `iSET` asserted on the same cycle as `rise` with 12:34:56 → time = 12:34:56, no `oSEC_PULSE`; assert `RST` mid-count at 07:15:30 → outputs zero asynchronously, before the next clock edge.
- `MODE_12H` = 1: set 00:00:00 → `oHOUR` 12, `oPM` 0; set 12:00:00 → 12, `oPM` 1; set 21:00:00 → 09, `oPM` 1; set 11:59:59 plus one tick → 12, `oPM` rises.
